// File: rtl/l1_cache_pkg.sv
// Shared geometry, FSM state encoding and line/tag types for the two-way L1 cache.
package l1_cache_pkg;

    localparam int TAG_W    = 24;
    localparam int SET_W    = 3;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int NUM_WAYS = 2;
    localparam int NUM_SETS = 1 << SET_W;

    typedef logic [1:0]        state_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [SET_W-1:0]  set_t;
    typedef logic [LINE_W-1:0] line_t;

    localparam state_t ST_CHECK     = 2'd0;
    localparam state_t ST_WRITEBACK = 2'd1;
    localparam state_t ST_ALLOCATE  = 2'd2;

    // Byte address of the first byte of a line.
    function automatic logic [31:0] line_addr(input tag_t tag, input set_t set);
        return {tag, set, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_cache_control.sv
// Cache FSM (CHECK / WRITEBACK / ALLOCATE), victim selection and LRU update.
// With L1_CACHE_ASSERT_EN defined, embedded protocol checks are compiled in.
import l1_cache_pkg::*;

module l1_cache_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_read_i,
    input  logic       req_write_i,
    input  logic [1:0] hit_i,
    input  logic [1:0] valid_i,
    input  logic [1:0] dirty_i,
    input  logic       lru_i,
    input  logic       pmem_resp_i,
    output state_t     state_o,
    output logic       hit_o,
    output logic       hit_way_o,
    output logic       victim_way_o,
    output logic       mem_resp_o,
    output logic       pmem_read_o,
    output logic       pmem_write_o,
    output logic       fill_we_o,
    output logic       lru_we_o,
    output logic       lru_d_o
);

    state_t state_q, state_d;
    logic   victim_q, victim_d;
    logic   req;
    logic   victim_sel;

    assign req       = req_read_i | req_write_i;
    assign hit_way_o = hit_i[0] ? 1'b0 : 1'b1;
    assign hit_o     = (state_q == ST_CHECK) && req && (|hit_i);

    // Invalid ways are filled before anything is evicted; way 0 wins ties.
    assign victim_sel = !valid_i[0] ? 1'b0 :
                        !valid_i[1] ? 1'b1 : lru_i;

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp_o   = 1'b0;
        pmem_read_o  = 1'b0;
        pmem_write_o = 1'b0;
        fill_we_o    = 1'b0;
        lru_we_o     = 1'b0;
        lru_d_o      = 1'b0;
        case (state_q)
            ST_CHECK: begin
                if (req) begin
                    if (|hit_i) begin
                        mem_resp_o = 1'b1;
                        lru_we_o   = 1'b1;
                        lru_d_o    = ~hit_way_o;
                    end else begin
                        victim_d = victim_sel;
                        state_d  = (valid_i[victim_sel] && dirty_i[victim_sel]) ?
                                   ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write_o = 1'b1;
                if (pmem_resp_i) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                pmem_read_o = 1'b1;
                if (pmem_resp_i) begin
                    fill_we_o = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            default: state_d = ST_CHECK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_CHECK;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    assign state_o      = state_q;
    assign victim_way_o = victim_q;

`ifdef L1_CACHE_ASSERT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (pmem_read_o && pmem_write_o)
                $error("l1_cache: pmem_read and pmem_write both asserted");
            if ((pmem_read_o || pmem_write_o) && !pmem_resp_i && (state_d != state_q))
                $error("l1_cache: state left while pmem request pending");
        end
    end
`endif

endmodule

// File: rtl/l1_cache.sv
// Two-way set-associative write-back L1 cache: tag/data arrays and word merge.
// Define L1_CACHE_ASSERT_EN to compile in embedded protocol assertions.
import l1_cache_pkg::*;

module l1_cache (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0] dirty_q [NUM_WAYS];
    logic [NUM_SETS-1:0] lru_q;
    tag_t                tag_q   [NUM_WAYS][NUM_SETS];
    line_t               data_q  [NUM_WAYS][NUM_SETS];

    set_t       set_idx;
    tag_t       req_tag;
    logic [2:0] word_idx;
    logic [1:0] unused_byte_off;

    assign set_idx         = mem_address[7:5];
    assign req_tag         = mem_address[31:8];
    assign word_idx        = mem_address[4:2];
    assign unused_byte_off = mem_address[1:0];

    state_t     state;
    logic       hit, hit_way, victim_way;
    logic       fill_we, lru_we, lru_d;
    logic [1:0] way_hit, way_valid, way_dirty;
    logic       write_hit;
    line_t      hit_line, merged_line;

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_valid[w] = valid_q[w][set_idx];
            way_dirty[w] = dirty_q[w][set_idx];
            way_hit[w]   = valid_q[w][set_idx] && (tag_q[w][set_idx] == req_tag);
        end
    end

    l1_cache_control u_control (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_read_i   (mem_read),
        .req_write_i  (mem_write),
        .hit_i        (way_hit),
        .valid_i      (way_valid),
        .dirty_i      (way_dirty),
        .lru_i        (lru_q[set_idx]),
        .pmem_resp_i  (pmem_resp),
        .state_o      (state),
        .hit_o        (hit),
        .hit_way_o    (hit_way),
        .victim_way_o (victim_way),
        .mem_resp_o   (mem_resp),
        .pmem_read_o  (pmem_read),
        .pmem_write_o (pmem_write),
        .fill_we_o    (fill_we),
        .lru_we_o     (lru_we),
        .lru_d_o      (lru_d)
    );

    // A simultaneous read and write request is serviced as a write.
    assign write_hit = hit && mem_write;

    always_comb begin
        hit_line    = data_q[hit_way][set_idx];
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b])
                merged_line[int'(word_idx)*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
        end
    end

    assign mem_rdata = hit_line[int'(word_idx)*32 +: 32];

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            ST_WRITEBACK: begin
                pmem_address = line_addr(tag_q[victim_way][set_idx], set_idx);
                pmem_wdata   = data_q[victim_way][set_idx];
            end
            ST_ALLOCATE: pmem_address = {mem_address[31:5], 5'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            lru_q   <= '0;
        end else begin
            if (fill_we) begin
                valid_q[victim_way][set_idx] <= 1'b1;
                dirty_q[victim_way][set_idx] <= 1'b0;
            end
            if (write_hit) dirty_q[hit_way][set_idx] <= 1'b1;
            if (lru_we)    lru_q[set_idx] <= lru_d;
        end
    end

    // Tags and data need no reset: nothing is read from a way until valid is set.
    always_ff @(posedge clk) begin
        if (!rst && fill_we) begin
            tag_q[victim_way][set_idx]  <= req_tag;
            data_q[victim_way][set_idx] <= pmem_rdata;
        end else if (write_hit) begin
            data_q[hit_way][set_idx] <= merged_line;
        end
    end

`ifdef L1_CACHE_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_read && mem_write)
                $error("l1_cache: mem_read and mem_write both asserted");
            if ((pmem_read || pmem_write) && (pmem_address[4:0] != 5'b0))
                $error("l1_cache: pmem_address not line aligned");
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed vector bench for l1_cache with a line-memory responder and a readback scoreboard.
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    l1_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line memory model and responder
    logic [255:0] model [logic [26:0]];
    int           fills = 0;
    int           wbs   = 0;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_line;
    bit           mem_hold = 0;

    initial begin
        int wait_cnt;
        int lat;
        wait_cnt   = 0;
        lat        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst && (pmem_read || pmem_write)) begin
                chk("pmem_rd_wr_exclusive", {pmem_read, pmem_write} == 2'b11, 1'b0);
            end
            if (!rst && (pmem_read || pmem_write) && !mem_hold) begin
                if (wait_cnt >= lat) begin
                    if (pmem_write) begin
                        model[pmem_address[31:5]] = pmem_wdata;
                        last_wb_addr = pmem_address;
                        last_wb_line = pmem_wdata;
                        wbs++;
                    end else begin
                        pmem_rdata = model.exists(pmem_address[31:5]) ?
                                     model[pmem_address[31:5]] : '0;
                        fills++;
                    end
                    pmem_resp = 1'b1;
                    wait_cnt  = 0;
                    lat       = $urandom_range(0, 2);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output int cycles, output bit ok);
        @(posedge clk); #1;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        ok     = 1'b0;
        rdata  = '0;
        cycles = 0;
        while (!ok && cycles < 60) begin
            @(negedge clk);
            if (mem_resp) begin
                ok    = 1'b1;
                rdata = mem_rdata;
            end else begin
                cycles++;
            end
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit           rst_first;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   be;
        logic [31:0]  exp_rdata;
        int           exp_fills;
        int           exp_wbs;
        logic [31:0]  exp_wb_addr;
        logic [255:0] exp_wb_line;
    } vec_t;

    vec_t vecs [16];
    logic [31:0] exp_q [$];

    initial begin
        logic [31:0] rdata;
        int          cycles;
        bit          ok;
        int          f0, w0;
        bit          seen;

        rst = 1'b1;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = '0; mem_byte_enable = '0;
        model[27'h0] = 256'h8;

        vecs[0]  = '{0, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h8,         1, 0, 32'h0, 256'h0};
        vecs[1]  = '{0, 1, 0, 32'hDEED_EE00, 32'h0, 4'h0, 32'h0,         1, 0, 32'h0, 256'h0};
        vecs[2]  = '{0, 1, 0, 32'h6666_6600, 32'h0, 4'h0, 32'h0,         1, 0, 32'h0, 256'h0};
        vecs[3]  = '{0, 1, 0, 32'hDEED_EE00, 32'h0, 4'h0, 32'h0,         0, 0, 32'h0, 256'h0};
        vecs[4]  = '{1, 0, 1, 32'h0000_0000, 32'h8, 4'hF, 32'h0,         1, 0, 32'h0, 256'h0};
        vecs[5]  = '{0, 0, 1, 32'hDEED_EE00, 32'h100, 4'hF, 32'h0,       1, 0, 32'h0, 256'h0};
        vecs[6]  = '{0, 0, 1, 32'h6666_6600, 32'h400, 4'hF, 32'h0,       1, 1, 32'h0, 256'h8};
        vecs[7]  = '{0, 1, 0, 32'h6666_6600, 32'h0, 4'h0, 32'h400,       0, 0, 32'h0, 256'h0};
        vecs[8]  = '{0, 1, 0, 32'hDEED_EE00, 32'h0, 4'h0, 32'h100,       0, 0, 32'h0, 256'h0};
        vecs[9]  = '{0, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 32'h8,         1, 1, 32'h6666_6600, 256'h400};
        vecs[10] = '{0, 0, 1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1, 0, 32'h0, 256'h0};
        vecs[11] = '{0, 0, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'h3, 32'h0, 0, 0, 32'h0, 256'h0};
        vecs[12] = '{0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h1122_CCDD, 0, 0, 32'h0, 256'h0};
        vecs[13] = '{0, 0, 1, 32'h0000_0024, 32'hCAFE_F00D, 4'h8, 32'h0, 0, 0, 32'h0, 256'h0};
        vecs[14] = '{0, 1, 0, 32'h0000_0024, 32'h0, 4'h0, 32'hCA00_0000, 0, 0, 32'h0, 256'h0};
        vecs[15] = '{0, 1, 0, 32'h0000_003C, 32'h0, 4'h0, 32'h0,         0, 0, 32'h0, 256'h0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_mem_resp",   mem_resp,     1'b0);
        chk("reset_pmem_read",  pmem_read,    1'b0);
        chk("reset_pmem_write", pmem_write,   1'b0);
        chk("reset_pmem_addr",  pmem_address, 32'h0);
        chk("reset_pmem_wdata", pmem_wdata,   256'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_first) pulse_reset();
            f0 = fills;
            w0 = wbs;
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                   rdata, cycles, ok);
            chk($sformatf("v%0d_resp", i), ok, 1'b1);
            if (vecs[i].rd) chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_fills", i), fills - f0, vecs[i].exp_fills);
            chk($sformatf("v%0d_wbs", i), wbs - w0, vecs[i].exp_wbs);
            if (vecs[i].exp_wbs > 0) begin
                chk($sformatf("v%0d_wb_addr", i), last_wb_addr, vecs[i].exp_wb_addr);
                chk($sformatf("v%0d_wb_line", i), last_wb_line, vecs[i].exp_wb_line);
            end
            if (vecs[i].exp_fills == 0) chk($sformatf("v%0d_hit_latency", i), cycles, 0);
        end

        // Write/readback sweep over four tags per set forces dirty evictions.
        for (int t = 0; t < 4; t++)
            for (int s = 0; s < 8; s++)
                for (int w = 0; w < 8; w += 5) begin
                    logic [31:0] a, d;
                    a = 32'h0100_0000 | (t << 8) | (s << 5) | (w << 2);
                    d = $urandom;
                    do_req(1'b0, 1'b1, a, d, 4'hF, rdata, cycles, ok);
                    chk("sweep_wr_resp", ok, 1'b1);
                    exp_q.push_back(d);
                end
        for (int t = 0; t < 4; t++)
            for (int s = 0; s < 8; s++)
                for (int w = 0; w < 8; w += 5) begin
                    logic [31:0] a;
                    a = 32'h0100_0000 | (t << 8) | (s << 5) | (w << 2);
                    do_req(1'b1, 1'b0, a, 32'h0, 4'h0, rdata, cycles, ok);
                    chk($sformatf("sweep_rd_%0h", a), rdata, exp_q.pop_front());
                end

        // Reset in the middle of a fill.
        do_req(1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'h0, rdata, cycles, ok);
        f0 = fills;
        do_req(1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'h0, rdata, cycles, ok);
        chk("pre_rst_hit_fills", fills - f0, 0);
        chk("pre_rst_hit_latency", cycles, 0);

        mem_hold = 1;
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_1000;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        chk("rst_alloc_pmem_read_seen", seen, 1'b1);
        chk("rst_alloc_pmem_addr", pmem_address, 32'h0000_1000);
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alloc_pmem_read", pmem_read, 1'b0);
        chk("rst_alloc_pmem_write", pmem_write, 1'b0);
        chk("rst_alloc_mem_resp", mem_resp, 1'b0);
        mem_hold = 0;

        f0 = fills;
        do_req(1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'h0, rdata, cycles, ok);
        chk("post_rst_resp", ok, 1'b1);
        chk("post_rst_miss_fills", fills - f0, 1);
        chk("post_rst_rdata", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
